// File: rtl/neuron_input_sequencer_if.sv
// Signal bundle between the word source, the input sequencer and the neuron accumulator.
`timescale 1ns/1ps
interface neuron_input_sequencer_if #(
    parameter int N      = 10,
    parameter int NUM_IN = 10
);
    logic                  START;
    logic [NUM_IN*N-1:0]   IN_FLAT;
    logic [N-1:0]          SUM;
    logic                  COUT;
    logic [N-1:0]          SEQ_D;
    logic                  ACC_CLR;
    logic                  BUSY;
    logic                  DONE;
    logic [N-1:0]          RESULT;
    logic                  OVF;

    modport master (
        output START, IN_FLAT, SUM, COUT,
        input  SEQ_D, ACC_CLR, BUSY, DONE, RESULT, OVF
    );

    modport slave (
        input  START, IN_FLAT, SUM, COUT,
        output SEQ_D, ACC_CLR, BUSY, DONE, RESULT, OVF
    );
endinterface

// File: rtl/neuron_input_sequencer.sv
// Streams a latched frame of NUM_IN words into the neuron accumulator and captures sum/overflow.
// Optional macro NIS_OVF_SAT_EN: saturate RESULT to all ones when the frame overflows.
//
// state  | meaning
// IDLE   | waiting for START; BUSY drops here one cycle after the capture
// CLR    | ACC_CLR high for one cycle, frame buffer loaded
// STREAM | one frame word per cycle on SEQ_D
// DRAIN  | SEQ_D held at 0 while the accumulator pipeline empties
// CAP    | RESULT/OVF captured on exit, DONE high in the following cycle
`timescale 1ns/1ps
module neuron_input_sequencer #(
    parameter int N         = 10,
    parameter int NUM_IN    = 10,
    parameter int DRAIN_CYC = 2
) (
    input logic                     CK,
    input logic                     RN,
    neuron_input_sequencer_if.slave bus
);
    localparam int IW = $clog2(NUM_IN + 1);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_IN);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, CAP} state_t;

    state_t              state;
    logic [NUM_IN*N-1:0] frame;
    logic [IW-1:0]       idx;
    logic [DW-1:0]       drain_cnt;
    logic                sticky;
    logic                ovf_now;
    logic [N-1:0]        cap_val;

    assign ovf_now = sticky | bus.COUT;

`ifdef NIS_OVF_SAT_EN
    assign cap_val = ovf_now ? '1 : bus.SUM;
`else
    assign cap_val = bus.SUM;
`endif

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state       <= IDLE;
            frame       <= '0;
            idx         <= '0;
            drain_cnt   <= '0;
            sticky      <= 1'b0;
            bus.SEQ_D   <= '0;
            bus.ACC_CLR <= 1'b0;
            bus.BUSY    <= 1'b0;
            bus.DONE    <= 1'b0;
            bus.RESULT  <= '0;
            bus.OVF     <= 1'b0;
        end else begin
            bus.DONE <= 1'b0;
            case (state)
                IDLE: begin
                    bus.BUSY    <= bus.START;
                    bus.ACC_CLR <= bus.START;
                    if (bus.START) begin
                        frame  <= bus.IN_FLAT;
                        sticky <= 1'b0;
                        state  <= CLR;
                    end
                end
                CLR: begin
                    // frame is consumed as a shift register: word 0 always sits in the low bits
                    bus.ACC_CLR <= 1'b0;
                    bus.SEQ_D   <= frame[N-1:0];
                    frame       <= frame >> N;
                    idx         <= {{(IW-1){1'b0}}, 1'b1};
                    state       <= STREAM;
                end
                STREAM: begin
                    sticky <= ovf_now;
                    if (idx == LAST_IDX) begin
                        bus.SEQ_D <= '0;
                        idx       <= '0;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= (DRAIN_CYC == 0) ? CAP : DRAIN;
                    end else begin
                        bus.SEQ_D <= frame[N-1:0];
                        frame     <= frame >> N;
                        idx       <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    sticky <= ovf_now;
                    if (drain_cnt == '0) begin
                        state <= CAP;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                CAP: begin
                    bus.RESULT <= cap_val;
                    bus.OVF    <= ovf_now;
                    bus.DONE   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_input_sequencer.sv
// Bench for neuron_input_sequencer: behavioural accumulator plus frame-level reference model.
`timescale 1ns/1ps
module tb_neuron_input_sequencer;
    localparam int N         = 10;
    localparam int NUM_IN    = 10;
    localparam int DRAIN_CYC = 2;
    localparam int L         = NUM_IN + DRAIN_CYC + 2;

`ifdef NIS_OVF_SAT_EN
    localparam logic [N-1:0] T2_RES = 10'h3FF;
    localparam logic [N-1:0] T5_RES = 10'h3FF;
`else
    localparam logic [N-1:0] T2_RES = 10'h3F8;
    localparam logic [N-1:0] T5_RES = 10'h3F6;
`endif

    logic CK = 1'b0;
    logic RN = 1'b0;
    always #5 CK = ~CK;

    neuron_input_sequencer_if #(.N(N), .NUM_IN(NUM_IN)) bi ();
    neuron_input_sequencer_if #(.N(N), .NUM_IN(1))      bs ();

    neuron_input_sequencer #(.N(N), .NUM_IN(NUM_IN), .DRAIN_CYC(DRAIN_CYC)) dut (
        .CK(CK), .RN(RN), .bus(bi.slave));
    neuron_input_sequencer #(.N(N), .NUM_IN(1), .DRAIN_CYC(2)) dut1 (
        .CK(CK), .RN(RN), .bus(bs.slave));

    // accumulator: input flip-flop, then sum register; clear hits both
    logic [N-1:0] acc_d, acc_s, acc1_d, acc1_s;
    logic [N:0]   acc_add, acc1_add;
    assign acc_add  = {1'b0, acc_s}  + {1'b0, acc_d};
    assign acc1_add = {1'b0, acc1_s} + {1'b0, acc1_d};
    assign bi.SUM  = acc_s;
    assign bi.COUT = acc_add[N];
    assign bs.SUM  = acc1_s;
    assign bs.COUT = acc1_add[N];

    always @(posedge CK or negedge RN) begin
        if (!RN || bi.ACC_CLR) begin
            acc_d <= '0; acc_s <= '0;
        end else begin
            acc_d <= bi.SEQ_D; acc_s <= acc_add[N-1:0];
        end
    end

    always @(posedge CK or negedge RN) begin
        if (!RN || bs.ACC_CLR) begin
            acc1_d <= '0; acc1_s <= '0;
        end else begin
            acc1_d <= bs.SEQ_D; acc1_s <= acc1_add[N-1:0];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // frame-level model: t = edges since the accepted START, -1 when no frame is in flight
    int                  t = -1;
    int                  m_total;
    logic [NUM_IN*N-1:0] m_frame = '0;
    logic [N-1:0]        m_res = '0;
    logic                m_ovf = 1'b0;

    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            t = -1; m_res = '0; m_ovf = 1'b0;
        end else if ((t < 0 || t == L) && bi.START) begin
            t = 0;
            m_frame = bi.IN_FLAT;
        end else if (t >= 0 && t < L) begin
            t = t + 1;
            if (t == L) begin
                m_total = 0;
                for (int k = 0; k < NUM_IN; k++) m_total += int'(m_frame[k*N +: N]);
                m_ovf = (m_total >= (1 << N));
                m_res = N'(m_total);
`ifdef NIS_OVF_SAT_EN
                if (m_ovf) m_res = '1;
`endif
            end
        end else begin
            t = -1;
        end
    end

    logic [N-1:0] exp_seq;
    always @(negedge CK) begin
        exp_seq = (t >= 1 && t <= NUM_IN) ? m_frame[(t-1)*N +: N] : '0;
        check("busy",    32'(bi.BUSY),    32'(t >= 0));
        check("acc_clr", 32'(bi.ACC_CLR), 32'(t == 0));
        check("seq_d",   32'(bi.SEQ_D),   32'(exp_seq));
        check("done",    32'(bi.DONE),    32'(t == L));
        check("result",  32'(bi.RESULT),  32'(m_res));
        check("ovf",     32'(bi.OVF),     32'(m_ovf));
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic run_frame(input logic [NUM_IN*N-1:0] f, input int mut_edge,
                             input logic [NUM_IN*N-1:0] mut_f, input bit order_chk,
                             output int done_edge);
        bi.IN_FLAT = f;
        bi.START   = 1'b1;
        tick();
        bi.START   = 1'b0;
        done_edge  = -1;
        for (int e = 1; e <= 40 && done_edge < 0; e++) begin
            if (e == mut_edge) bi.IN_FLAT = mut_f;
            tick();
            if (order_chk && e <= NUM_IN) check("order_seq_d", 32'(bi.SEQ_D), 32'(e));
            if (bi.DONE) done_edge = e;
        end
        check("done_seen", 32'(done_edge >= 0), 32'd1);
    endtask

    function automatic logic [NUM_IN*N-1:0] rand_frame();
        logic [NUM_IN*N-1:0] f;
        int                  top;
        top = ($urandom_range(0, 1) == 0) ? 63 : 1023;
        for (int k = 0; k < NUM_IN; k++) f[k*N +: N] = N'($urandom_range(0, top));
        return f;
    endfunction

    initial begin
        logic [NUM_IN*N-1:0] f;
        int de, n_done, first, second;

        bi.START = 1'b0; bi.IN_FLAT = '0;
        bs.START = 1'b0; bs.IN_FLAT = '0;
        RN = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        check("rst_seq_d",  32'(bi.SEQ_D),  32'd0);
        check("rst_busy",   32'(bi.BUSY),   32'd0);
        check("rst_result", 32'(bi.RESULT), 32'd0);
        check("rst1_done",  32'(bs.DONE),   32'd0);
        RN = 1'b1;
        tick(); tick();

        // words 1..10
        for (int k = 0; k < NUM_IN; k++) f[k*N +: N] = N'(k + 1);
        run_frame(f, -1, '0, 1'b1, de);
        check("t1_done_edge", 32'(de), 32'd14);
        check("t1_result", 32'(bi.RESULT), 32'h037);
        check("t1_ovf", 32'(bi.OVF), 32'd0);

        // {0, 0xFF x8, 0}
        f = '0;
        for (int k = 1; k <= 8; k++) f[k*N +: N] = 10'h0FF;
        run_frame(f, -1, '0, 1'b0, de);
        check("t2_done_edge", 32'(de), 32'd14);
        check("t2_result", 32'(bi.RESULT), 32'(T2_RES));
        check("t2_ovf", 32'(bi.OVF), 32'd1);

        // START at edges 0, 5, 14, 15
        for (int k = 0; k < NUM_IN; k++) f[k*N +: N] = N'(k + 1);
        bi.IN_FLAT = f;
        bi.START   = 1'b1;
        tick();
        n_done = 0; first = -1; second = -1;
        for (int e = 1; e <= 31; e++) begin
            bi.START = (e == 5 || e == 14 || e == 15);
            tick();
            if (bi.DONE) begin
                n_done++;
                if (first < 0) first = e; else second = e;
            end
        end
        bi.START = 1'b0;
        check("t3_done_count", 32'(n_done), 32'd2);
        check("t3_first_done", 32'(first), 32'd14);
        check("t3_second_done", 32'(second), 32'd29);

        // IN_FLAT rewritten mid-frame
        for (int k = 0; k < NUM_IN; k++) f[k*N +: N] = N'(k * 7 + 3);
        run_frame(f, 3, ~f, 1'b0, de);
        check("t4_result", 32'(bi.RESULT), 32'h159);
        check("t4_ovf", 32'(bi.OVF), 32'd0);

        // reset mid-STREAM
        for (int k = 0; k < NUM_IN; k++) f[k*N +: N] = N'(k + 1);
        bi.IN_FLAT = f;
        bi.START   = 1'b1;
        tick();
        bi.START   = 1'b0;
        repeat (7) tick();
        RN = 1'b0;
        #1;
        check("t5_rst_seq_d",   32'(bi.SEQ_D),   32'd0);
        check("t5_rst_busy",    32'(bi.BUSY),    32'd0);
        check("t5_rst_acc_clr", 32'(bi.ACC_CLR), 32'd0);
        check("t5_rst_result",  32'(bi.RESULT),  32'd0);
        check("t5_rst_ovf",     32'(bi.OVF),     32'd0);
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 3) RN = 1'b1;
            tick();
            if (bi.DONE) n_done++;
        end
        check("t5_no_done", 32'(n_done), 32'd0);
        run_frame('1, -1, '0, 1'b0, de);
        check("t5_done_edge", 32'(de), 32'd14);
        check("t5_result", 32'(bi.RESULT), 32'(T5_RES));
        check("t5_ovf", 32'(bi.OVF), 32'd1);

        // single-word frame
        bs.IN_FLAT = 10'h155;
        bs.START   = 1'b1;
        tick();
        bs.START   = 1'b0;
        de = -1;
        for (int e = 1; e <= 20 && de < 0; e++) begin
            tick();
            if (bs.DONE) de = e;
        end
        check("t6_done_edge", 32'(de), 32'd5);
        check("t6_result", 32'(bs.RESULT), 32'h155);
        check("t6_ovf", 32'(bs.OVF), 32'd0);

        // random START traffic, IN_FLAT churn and one reset pulse
        for (int c = 0; c < 600; c++) begin
            bi.START = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) bi.IN_FLAT = rand_frame();
            if (c == 300) RN = 1'b0;
            if (c == 302) RN = 1'b1;
            tick();
        end
        bi.START = 1'b0;
        repeat (L + 3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
